// File: rtl/uart_big_pkg.sv
// Shared types and constants for the RS-485 burst UART receiver.
// Optional feature macro: UARTRX_TIMEOUT_EN (partial-frame idle timeout).
package uart_big_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 8;
    localparam int unsigned IDX_W          = 5;
    localparam int unsigned ADDR_W         = 9;
    localparam int unsigned CYC_W          = 6;
    localparam int unsigned DATA_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        HOLD
    } state_t;

    // One frame-RAM write: slot address plus received byte.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Slot address: byte index offset into a 4-byte-aligned slot, 9-bit wrap.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] idx,
                                                    input logic [CYC_W-1:0] cyc);
        return ADDR_W'(idx) + ADDR_W'({cyc, 2'b00});
    endfunction

endpackage

// File: rtl/uart_rx_big_if.sv
// Serial line in, frame-RAM write port and frame handshake out.
// Optional feature macro: UARTRX_TIMEOUT_EN (drives tout when defined).
interface uart_rx_big_if;
    import uart_big_pkg::*;

    logic              rx;
    logic [CYC_W-1:0]  cycle;
    logic              ack;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              full;
    logic              ferr;
    logic              tout;

    // Receiver side: consumes the line and ack, produces writes and flags.
    modport master (
        input  rx, cycle, ack,
        output addr, wdata, we, full, ferr, tout
    );

    // Line driver / frame RAM side.
    modport slave (
        output rx, cycle, ack,
        input  addr, wdata, we, full, ferr, tout
    );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser with configurable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_big.sv
// RS-485 burst receiver: 8N1 deserialiser writing BYTES-byte frames into slot RAM.
// Optional feature macro: UARTRX_TIMEOUT_EN drops a stalled partial frame after
// TIMEOUT_BITS idle bit-times and pulses tout; otherwise tout is held at 0.
module uart_rx_big
    import uart_big_pkg::*;
#(
    parameter int unsigned BYTES      = 4,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UARTRX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_BITS = 12
`endif
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_big_if.master bus
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    logic              rx_s;
    logic              ack_s;
    logic              rx_prev;

    state_t            state_q, state_n;
    logic [PH_W-1:0]   phase_q, phase_n;
    logic [2:0]        bit_q, bit_n;
    logic [7:0]        sh_q, sh_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic              ack_seen_q, ack_seen_n;
    wr_t               wr_q, wr_n;
    logic              we_q, we_n;
    logic              full_q, full_n;
    logic              ferr_q, ferr_n;
    logic              tout_q, tout_n;

`ifdef UARTRX_TIMEOUT_EN
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int unsigned IDLE_W  = $clog2(TO_CLKS);
    logic [IDLE_W-1:0] idle_q, idle_n;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    uart_sync2 #(.RST_VAL(1'b0)) u_sync_ack (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ack),
        .q     (ack_s)
    );

    // Next-state and next-output logic for the receive FSM.
    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        bit_n      = bit_q;
        sh_n       = sh_q;
        idx_n      = idx_q;
        ack_seen_n = ack_seen_q;
        wr_n       = wr_q;
        we_n       = 1'b0;
        full_n     = full_q;
        ferr_n     = 1'b0;
        tout_n     = 1'b0;
`ifdef UARTRX_TIMEOUT_EN
        idle_n     = '0;
`endif

        case (state_q)
            IDLE: begin
                // A falling edge needs a prior high, so a line stuck low after a
                // framing error cannot retrigger.
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    phase_n = '0;
                end
`ifdef UARTRX_TIMEOUT_EN
                else if (idx_q != '0 && idx_q < IDX_W'(BYTES)) begin
                    if (idle_q == IDLE_W'(TO_CLKS - 1)) begin
                        idx_n  = '0;
                        tout_n = 1'b1;
                    end else begin
                        idle_n = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end

            START: begin
                if (phase_q == PH_W'(OVERSAMPLE / 2 - 1)) begin
                    phase_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase_q + PH_W'(1);
                end
            end

            DATA: begin
                if (phase_q == PH_W'(OVERSAMPLE - 1)) begin
                    phase_n = '0;
                    sh_n    = {rx_s, sh_q[7:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    phase_n = phase_q + PH_W'(1);
                end
            end

            STOP: begin
                if (phase_q == PH_W'(OVERSAMPLE - 1)) begin
                    phase_n = '0;
                    if (rx_s) begin
                        we_n      = 1'b1;
                        wr_n.data = sh_q;
                        wr_n.addr = slot_addr(idx_q, bus.cycle);
                        idx_n     = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(BYTES - 1)) begin
                            state_n = HOLD;
                            full_n  = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase_q + PH_W'(1);
                end
            end

            HOLD: begin
                // Release on ack high, then rearm only once ack has dropped again.
                if (!ack_seen_q) begin
                    if (ack_s) begin
                        full_n     = 1'b0;
                        idx_n      = '0;
                        ack_seen_n = 1'b1;
                    end
                end else if (!ack_s) begin
                    ack_seen_n = 1'b0;
                    state_n    = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            ack_seen_q <= 1'b0;
            rx_prev    <= 1'b1;
            wr_q       <= '0;
            we_q       <= 1'b0;
            full_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tout_q     <= 1'b0;
`ifdef UARTRX_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            bit_q      <= bit_n;
            sh_q       <= sh_n;
            idx_q      <= idx_n;
            ack_seen_q <= ack_seen_n;
            rx_prev    <= rx_s;
            wr_q       <= wr_n;
            we_q       <= we_n;
            full_q     <= full_n;
            ferr_q     <= ferr_n;
            tout_q     <= tout_n;
`ifdef UARTRX_TIMEOUT_EN
            idle_q     <= idle_n;
`endif
        end
    end

    assign bus.addr  = wr_q.addr;
    assign bus.wdata = wr_q.data;
    assign bus.we    = we_q;
    assign bus.full  = full_q;
    assign bus.ferr  = ferr_q;
    assign bus.tout  = tout_q;

endmodule

// File: tb/tb_uart_rx_big.sv
// Self-checking bench for uart_rx_big (BYTES=4, OVERSAMPLE=8, TIMEOUT_BITS=12).
// Expectations follow UARTRX_TIMEOUT_EN when it is defined for the build.
module tb_uart_rx_big;

    localparam int OS      = 8;
    localparam int NB      = 4;
    localparam int TO_BITS = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_big_if bus();

    uart_rx_big dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    int ferr_cnt = 0;
    int tout_cnt = 0;
    int ovl_cnt  = 0;

    // Reference model: byte index in the current frame and frame-held flag.
    int m_idx  = 0;
    bit m_hold = 0;

    // Passive observer of the write port and pulse outputs.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.we) got_q.push_back({bus.addr, bus.wdata});
            if (bus.ferr) ferr_cnt++;
            if (bus.tout) tout_cnt++;
            if (bus.we && bus.ferr) ovl_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame, LSB first, followed by two idle bit-times.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (OS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (OS) @(posedge clk);
        end
        bus.rx = stop_bit;
        repeat (OS) @(posedge clk);
        bus.rx = 1'b1;
        repeat (2 * OS) @(posedge clk);
    endtask

    // Good byte: model expects a write unless a full frame is being held.
    task automatic rx_good(input logic [7:0] d);
        if (!m_hold) begin
            exp_q.push_back({9'((m_idx + 4 * int'(bus.cycle)) % 512), d});
            m_idx++;
            if (m_idx == NB) m_hold = 1;
        end
        send_byte(d, 1'b1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [16:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  bus.addr,  0);
        check({tag, "_wdata"}, bus.wdata, 0);
        check({tag, "_we"},    bus.we,    0);
        check({tag, "_full"},  bus.full,  0);
        check({tag, "_ferr"},  bus.ferr,  0);
        check({tag, "_tout"},  bus.tout,  0);
    endtask

    // Ack handshake: full must clear within 3 clocks of ack rising.
    task automatic do_ack();
        bus.ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full_clear_on_ack", bus.full, 0);
        bus.ack = 1'b0;
        repeat (6) @(posedge clk);
        m_idx  = 0;
        m_hold = 0;
    endtask

    initial begin
        int f0, t0;
        bus.rx    = 1'b1;
        bus.cycle = 6'd3;
        bus.ack   = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Directed frame: four bytes into slot 3.
        rx_good(8'hA5);
        rx_good(8'h3C);
        rx_good(8'hFF);
        rx_good(8'h00);
        check_writes("frame_slot3");
        check("full_after_4th", bus.full, 1);

        // Byte during HOLD is ignored.
        rx_good(8'h77);
        check_writes("hold_ignore");
        check("full_held", bus.full, 1);
        do_ack();

        // Framing error: no write, ferr pulse, next byte at the same address.
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check_writes("ferr_no_write");
        rx_good(8'h12);
        check_writes("after_ferr");

        // Short glitch in IDLE: nothing happens, receiver stays armed.
        f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (OS / 4) @(posedge clk);
        bus.rx = 1'b1;
        repeat (4 * OS) @(posedge clk);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check_writes("glitch_no_write");
        rx_good(8'($urandom));
        check_writes("after_glitch");

        // Two bytes in, then a long idle gap.
        t0 = tout_cnt;
        repeat ((TO_BITS + 2) * OS) @(posedge clk);
`ifdef UARTRX_TIMEOUT_EN
        check("timeout_pulse", tout_cnt - t0, 1);
        m_idx = 0;
`else
        check("no_timeout", tout_cnt - t0, 0);
`endif
        rx_good(8'($urandom));
        check_writes("after_idle");
        while (!m_hold) rx_good(8'($urandom));
        check_writes("idle_frame_rest");
        check("full_idle_frame", bus.full, 1);
        do_ack();

        // Randomised frames with slot changes between bytes.
        for (int fr = 0; fr < 3; fr++) begin
            bus.cycle = 6'($urandom_range(0, 63));
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 3) == 0) bus.cycle = 6'($urandom_range(0, 63));
                rx_good(8'($urandom));
            end
            check_writes("rand_frame");
            check("rand_full", bus.full, 1);
            do_ack();
        end

        // Reset in the middle of the second byte's data bits.
        bus.cycle = 6'd5;
        rx_good(8'($urandom));
        check_writes("pre_reset_byte");
        bus.rx = 1'b0;
        repeat (OS) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.rx = 1'($urandom);
            repeat (OS) @(posedge clk);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        bus.rx = 1'b1;
        m_idx  = 0;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        rx_good(8'h9C);
        check_writes("post_reset");

        check("we_ferr_overlap", ovl_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
